// File: rtl/rgmii_ddr_rx_if.sv
// rgmii_ddr_rx_if
// Bundles the RGMII receive pins and the byte-wide frame stream of rgmii_ddr_rx.
//   rxd, rx_ctl          : DDR receive pins from the PHY
//   out_data/out_valid   : one byte per strobe, preamble and SFD removed
//   out_last/out_error   : end-of-frame marker and RX_ER-seen flag
//   frame_count/drop_count : delivered / discarded frame counters
// master = receiver (drives the stream), slave = PHY model / MAC side.
interface rgmii_ddr_rx_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [3:0]             rxd;
    logic                   rx_ctl;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_error;
    logic [COUNT_WIDTH-1:0] frame_count;
    logic [COUNT_WIDTH-1:0] drop_count;

    modport master (
        input  rxd, rx_ctl,
        output out_data, out_valid, out_last, out_error, frame_count, drop_count
    );

    modport slave (
        output rxd, rx_ctl,
        input  out_data, out_valid, out_last, out_error, frame_count, drop_count
    );
endinterface

// File: rtl/rgmii_ddr_rx.sv
// rgmii_ddr_rx
// RGMII DDR receive path: captures rxd/rx_ctl on both edges of C, rebuilds
// bytes, strips preamble/SFD and emits a byte stream with last/error markers.
//   C   : receive clock, both edges sample the pins
//   R   : asynchronous active-high reset
//   bus : rgmii_ddr_rx_if.master (pins in, frame stream and counters out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no carrier, waiting for the first preamble byte
// PREAMBLE  | inside 0x55 run, waiting for SFD
// DATA      | payload; one byte held back so the last one can carry out_last
// DROP      | malformed start, discarding until carrier drops
module rgmii_ddr_rx #(
    parameter int COUNT_WIDTH = 16
) (
    input logic            C,
    input logic            R,
    rgmii_ddr_rx_if.master bus
);
    localparam logic [7:0] BYTE_PRE = 8'h55;
    localparam logic [7:0] BYTE_SFD = 8'hD5;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t                 r_state;
    logic [3:0]             r_lo;
    logic [3:0]             r_hi;
    logic                   r_dv;
    logic                   r_ctl_f;
    logic [7:0]             r_pair_byte;
    logic                   r_pair_dv;
    logic                   r_pair_er;
    logic [7:0]             r_hold;
    logic                   r_hold_full;
    logic                   r_err_flag;
    logic [7:0]             r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_out_error;
    logic [COUNT_WIDTH-1:0] r_frame_count;
    logic [COUNT_WIDTH-1:0] r_drop_count;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_lo <= 4'h0;
            r_dv <= 1'b0;
        end else begin
            r_lo <= bus.rxd;
            r_dv <= bus.rx_ctl;
        end
    end

    always_ff @(negedge C or posedge R) begin
        if (R) begin
            r_hi    <= 4'h0;
            r_ctl_f <= 1'b0;
        end else begin
            r_hi    <= bus.rxd;
            r_ctl_f <= bus.rx_ctl;
        end
    end

    // Realign both halves into the rising-edge domain; falling ctl carries DV^ER.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_pair_byte <= 8'h00;
            r_pair_dv   <= 1'b0;
            r_pair_er   <= 1'b0;
        end else begin
            r_pair_byte <= {r_hi, r_lo};
            r_pair_dv   <= r_dv;
            r_pair_er   <= r_dv ^ r_ctl_f;
        end
    end

    // dv=0 with er=1 (false carrier / extend) is treated as plain idle:
    // er is only looked at while dv=1 in DATA.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_state       <= S_IDLE;
            r_hold        <= 8'h00;
            r_hold_full   <= 1'b0;
            r_err_flag    <= 1'b0;
            r_out_data    <= 8'h00;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_error   <= 1'b0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pair_dv)
                        r_state <= (r_pair_byte == BYTE_PRE) ? S_PREAMBLE : S_DROP;
                end
                S_PREAMBLE: begin
                    if (!r_pair_dv) begin
                        r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
                        r_state      <= S_IDLE;
                    end else if (r_pair_byte == BYTE_SFD) begin
                        r_hold_full <= 1'b0;
                        r_err_flag  <= 1'b0;
                        r_state     <= S_DATA;
                    end else if (r_pair_byte != BYTE_PRE) begin
                        r_state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (r_pair_dv) begin
                        if (r_hold_full) begin
                            r_out_data  <= r_hold;
                            r_out_valid <= 1'b1;
                        end
                        r_hold      <= r_pair_byte;
                        r_hold_full <= 1'b1;
                        r_err_flag  <= r_err_flag | r_pair_er;
                    end else begin
                        if (r_hold_full) begin
                            r_out_data    <= r_hold;
                            r_out_valid   <= 1'b1;
                            r_out_last    <= 1'b1;
                            r_out_error   <= r_err_flag;
                            r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
                        end else begin
                            r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
                        end
                        r_hold_full <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (!r_pair_dv) begin
                        r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
    assign bus.out_error   = r_out_error;
    assign bus.frame_count = r_frame_count;
    assign bus.drop_count  = r_drop_count;
endmodule

// File: tb/tb_rgmii_ddr_rx.sv
// tb_rgmii_ddr_rx
// Drives RGMII DDR frames into rgmii_ddr_rx and checks the byte stream and
// counters. A second instance with 3-bit counters shares the pins so counter
// wrap-around is exercised within a short run.
module tb_rgmii_ddr_rx;
    typedef logic [7:0] bq_t[$];
    typedef bit eq_t[$];
    typedef struct { logic [7:0] d; bit last; bit err; int cyc; } beat_t;
    typedef struct { logic [7:0] d; bit last; bit err; } exp_t;
    typedef struct {
        int         pre_len;
        logic [7:0] sfd;
        int         pay_len;
        logic [7:0] first;
        int         er_idx;
        int         exp_beats;
        bit         exp_err;
        int         f_inc;
        int         d_inc;
    } vec_t;

    logic C = 1'b0;
    logic R;
    always #4 C = ~C;

    int cyc = 0;
    always @(posedge C) cyc <= cyc + 1;

    rgmii_ddr_rx_if #(.COUNT_WIDTH(16)) bus ();
    rgmii_ddr_rx_if #(.COUNT_WIDTH(3))  bus_w ();

    rgmii_ddr_rx #(.COUNT_WIDTH(16)) dut   (.C(C), .R(R), .bus(bus));
    rgmii_ddr_rx #(.COUNT_WIDTH(3))  dut_w (.C(C), .R(R), .bus(bus_w));

    assign bus_w.rxd    = bus.rxd;
    assign bus_w.rx_ctl = bus.rx_ctl;

    int n_checks = 0;
    int n_errors = 0;
    int viol     = 0;
    int exp_frames = 0;
    int exp_drops  = 0;

    beat_t got_q[$];
    exp_t  exp_q[$];
    int    edge_q[$];
    bq_t   fb;
    eq_t   fe;
    vec_t  vecs[8];

    logic [7:0] prev_data = 8'h00;
    logic       prev_r    = 1'b1;

    always @(negedge C) begin
        if (bus.out_valid) begin
            got_q.push_back('{bus.out_data, bus.out_last, bus.out_error, cyc});
        end else if (!R && !prev_r) begin
            if (bus.out_last || bus.out_error) viol++;
            if (bus.out_data != prev_data) viol++;
        end
        prev_data = bus.out_data;
        prev_r    = R;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called in the low phase; leaves the caller in the next low phase.
    task automatic put(input logic [7:0] b, input bit dv, input bit er);
        bus.rxd    = b[3:0];
        bus.rx_ctl = dv;
        @(posedge C);
        #1;
        edge_q.push_back(cyc);
        bus.rxd    = b[7:4];
        bus.rx_ctl = dv ^ er;
        @(negedge C);
        #1;
    endtask

    task automatic send_frame(input bq_t b, input eq_t e, input int gap);
        edge_q.delete();
        foreach (b[i]) put(b[i], 1'b1, e[i]);
        repeat (gap) put(8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, " frame_count"}, bus.frame_count, exp_frames);
        check({tag, " drop_count"}, bus.drop_count, exp_drops);
        check({tag, " frame_count_w3"}, bus_w.frame_count, exp_frames % 8);
        check({tag, " drop_count_w3"}, bus_w.drop_count, exp_drops % 8);
    endtask

    task automatic compare_q(input string tag);
        check({tag, " beat_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, " beat"}, {got_q[i].d, got_q[i].last, got_q[i].err},
                  {exp_q[i].d, exp_q[i].last, exp_q[i].err});
        got_q.delete();
        exp_q.delete();
    endtask

    // Frame-level reference: classify the byte sequence, queue expected beats.
    function automatic void model_frame(input bq_t b, input eq_t e);
        int i = 0;
        bit err = 1'b0;
        if (b.size() == 0) return;
        if (b[0] != 8'h55) begin
            exp_drops++;
            return;
        end
        while (i < b.size() && b[i] == 8'h55) i++;
        if (i >= b.size() - 1 || b[i] != 8'hD5) begin
            exp_drops++;
            return;
        end
        for (int j = i + 1; j < b.size(); j++) begin
            err |= e[j];
            exp_q.push_back('{b[j], j == b.size() - 1, (j == b.size() - 1) ? err : 1'b0});
        end
        exp_frames++;
    endfunction

    function automatic logic [7:0] rand_not_pre();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
        return b;
    endfunction

    function automatic void add(input logic [7:0] b, input bit er);
        fb.push_back(b);
        fe.push_back(er);
    endfunction

    int kind, pre, pay, gapn, last_i;

    initial begin
        //           pre  sfd    pay first  er  beats err f d
        vecs[0] = '{7,  8'hD5, 64, 8'h01, -1, 64, 1'b0, 1, 0};
        vecs[1] = '{7,  8'hD5, 64, 8'h01,  9, 64, 1'b1, 1, 0};
        vecs[2] = '{2,  8'hA5,  5, 8'h10, -1,  0, 1'b0, 0, 1};
        vecs[3] = '{1,  8'hD5,  0, 8'h00, -1,  0, 1'b0, 0, 1};
        vecs[4] = '{1,  8'hD5,  1, 8'hAA, -1,  1, 1'b0, 1, 0};
        vecs[5] = '{0,  8'hD5,  4, 8'h20, -1,  0, 1'b0, 0, 1};
        vecs[6] = '{20, 8'hD5,  3, 8'h55, -1,  3, 1'b0, 1, 0};
        vecs[7] = '{3,  8'hD5,  2, 8'hFF,  1,  2, 1'b1, 1, 0};

        R          = 1'b1;
        bus.rxd    = 4'h0;
        bus.rx_ctl = 1'b0;
        repeat (3) @(negedge C);
        #1;
        check("reset out_data", bus.out_data, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset out_error", bus.out_error, 0);
        check_counts("reset");
        R = 1'b0;
        repeat (3) put(8'h00, 1'b0, 1'b0);

        // Directed table: one frame per record, expectations are constants.
        foreach (vecs[v]) begin
            fb.delete();
            fe.delete();
            repeat (vecs[v].pre_len) add(8'h55, 1'b0);
            add(vecs[v].sfd, 1'b0);
            for (int j = 0; j < vecs[v].pay_len; j++)
                add(8'(vecs[v].first + 8'(j)), j == vecs[v].er_idx);
            got_q.delete();
            send_frame(fb, fe, 6);
            check($sformatf("vec%0d beats", v), got_q.size(), vecs[v].exp_beats);
            last_i = vecs[v].exp_beats - 1;
            for (int j = 0; j < got_q.size() && j < vecs[v].exp_beats; j++)
                check($sformatf("vec%0d beat%0d", v, j),
                      {got_q[j].d, got_q[j].last, got_q[j].err},
                      {8'(vecs[v].first + 8'(j)), j == last_i,
                       (j == last_i) ? vecs[v].exp_err : 1'b0});
            if (vecs[v].exp_beats > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d latency", v),
                      got_q[0].cyc - edge_q[vecs[v].pre_len + 1], 3);
                check($sformatf("vec%0d back_to_back", v),
                      got_q[got_q.size() - 1].cyc - got_q[0].cyc, got_q.size() - 1);
            end
            got_q.delete();
            exp_frames += vecs[v].f_inc;
            exp_drops  += vecs[v].d_inc;
            check_counts($sformatf("vec%0d", v));
        end

        // False carrier: dv=0, er=1 for 20 cycles changes nothing.
        repeat (20) put(8'($urandom), 1'b0, 1'b1);
        check("false_carrier beats", got_q.size(), 0);
        check_counts("false_carrier");

        // Bad preamble then good frame after one idle; then 0xAA / 0xBB 1-byte frames.
        fb.delete(); fe.delete();
        add(8'h55, 0); add(8'h55, 0); add(8'hA5, 0); add(8'h11, 0); add(8'h22, 0);
        model_frame(fb, fe);
        send_frame(fb, fe, 1);
        fb.delete(); fe.delete();
        repeat (7) add(8'h55, 0);
        add(8'hD5, 0);
        for (int j = 0; j < 10; j++) add(8'(8'h80 + 8'(j)), 0);
        model_frame(fb, fe);
        send_frame(fb, fe, 1);
        fb.delete(); fe.delete();
        add(8'h55, 0); add(8'hD5, 0); add(8'hAA, 0);
        model_frame(fb, fe);
        send_frame(fb, fe, 1);
        fb.delete(); fe.delete();
        add(8'h55, 0); add(8'hD5, 0); add(8'hBB, 0);
        model_frame(fb, fe);
        send_frame(fb, fe, 6);
        compare_q("b2b");
        check_counts("b2b");

        // Reset pulsed during payload byte 30 (0x1E).
        edge_q.delete();
        repeat (7) put(8'h55, 1'b1, 1'b0);
        put(8'hD5, 1'b1, 1'b0);
        for (int j = 1; j < 30; j++) put(8'(j), 1'b1, 1'b0);
        bus.rxd    = 4'hE;
        bus.rx_ctl = 1'b1;
        @(posedge C);
        #1;
        R = 1'b1;
        #1;
        check("mid_reset out_valid", bus.out_valid, 0);
        check("mid_reset out_data", bus.out_data, 0);
        check("mid_reset out_last", bus.out_last, 0);
        check("mid_reset frame_count", bus.frame_count, 0);
        check("mid_reset drop_count", bus.drop_count, 0);
        bus.rxd = 4'h1;
        @(negedge C);
        #1;
        R = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int j = 31; j <= 64; j++) put(8'(j), 1'b1, 1'b0);
        repeat (6) put(8'h00, 1'b0, 1'b0);
        check("after_reset beats", got_q.size(), 0);
        exp_frames = 0;
        exp_drops  = 1;
        check_counts("after_reset");
        fb.delete(); fe.delete();
        repeat (7) add(8'h55, 0);
        add(8'hD5, 0);
        for (int j = 0; j < 8; j++) add(8'(8'hC0 + 8'(j)), 0);
        model_frame(fb, fe);
        send_frame(fb, fe, 6);
        compare_q("post_reset");
        check_counts("post_reset");

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            pre  = $urandom_range(1, 8);
            pay  = $urandom_range(1, 24);
            gapn = $urandom_range(1, 3);
            fb.delete();
            fe.delete();
            if (kind == 4) begin
                add(rand_not_pre(), $urandom_range(0, 15) == 0);
            end else begin
                repeat (pre) add(8'h55, $urandom_range(0, 15) == 0);
                add((kind == 2) ? rand_not_pre() : 8'hD5, $urandom_range(0, 15) == 0);
            end
            if (kind != 3)
                repeat (pay) add(8'($urandom), $urandom_range(0, 15) == 0);
            model_frame(fb, fe);
            edge_q.delete();
            foreach (fb[i]) put(fb[i], 1'b1, fe[i]);
            repeat (gapn) put(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        end
        repeat (6) put(8'h00, 1'b0, 1'b0);
        compare_q("rand");
        check_counts("rand");

        check("stream invariants", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rgmii_ddr_rx.md
# rgmii_ddr_rx

Receive-side counterpart of the DDR output path: captures the 4-bit double-data-rate RGMII receive bus on both edges of the receive clock, rebuilds bytes, decodes RX_CTL into data-valid/error, strips preamble and SFD, and presents one byte-wide frame stream with last/error markers. It sits between the PHY pins and the Ethernet MAC receive logic and runs entirely in the PHY receive-clock domain. There is no backpressure.

## Interface
- `COUNT_WIDTH`, 16: width of the frame and drop counters.
- `C`  input  1  receive clock (125 MHz); both edges sample `rxd`/`rx_ctl`.
- `R`  input  1  reset, asynchronous, active-high.
- `rxd`  input  4  DDR data: low nibble on rising edge, high nibble on falling edge.
- `rx_ctl`  input  1  DDR control: RX_DV on rising edge, RX_DV xor RX_ER on falling edge.
- `out_data`  output  8  frame byte, SFD and preamble removed.
- `out_valid`  output  1  one-cycle strobe per byte.
- `out_last`  output  1  qualifies the final byte of a frame.
- `out_error`  output  1  valid only with `out_last`: RX_ER was seen during the frame.
- `frame_count`  output  COUNT_WIDTH  frames delivered (incremented on each `out_last` beat).
- `drop_count`  output  COUNT_WIDTH  frames discarded (bad preamble/SFD, or empty after SFD).

## Operation
- Capture stage: rising-edge registers `lo`, `dv`; falling-edge registers `hi`, `ctl_f`. At the next rising edge the pair register loads `{hi, lo}`, `dv`, `er = dv ^ ctl_f` (same-edge pipelined alignment). All capture registers clear to 0 on `R`.
- FSM, advanced once per rising edge on the pair register:
  - IDLE: `dv=0` stay. `dv=1` and byte 0x55 -> PREAMBLE. `dv=1` and any other byte -> DROP.
  - PREAMBLE: byte 0x55 stay (no length limit). 0xD5 -> DATA, hold register empty, error flag cleared. Other byte -> DROP. `dv=0` -> IDLE, `drop_count`+1.
  - DATA: `dv=1`: if hold register full, emit held byte (`out_valid=1`, `out_last=0`); load new byte into hold; OR `er` into error flag. `dv=0`: if hold full, emit held byte with `out_last=1`, `out_error`=flag, `frame_count`+1; if hold empty (SFD then carrier drop), emit nothing, `drop_count`+1; -> IDLE.
  - DROP: wait for `dv=0`, then `drop_count`+1 -> IDLE.
- `dv=0` with `er=1` (false carrier / carrier extend) is ignored in every state.
- Counters wrap modulo 2^COUNT_WIDTH.
- `out_data` holds its last value when `out_valid=0`; `out_last`/`out_error` are 0 whenever `out_valid=0`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `out_error`=0, both counters 0, FSM IDLE, hold empty.
- Latency: byte whose low nibble is sampled at rising edge k is on `out_data` with `out_valid=1` in the cycle after rising edge k+3. Fixed for every byte, including the last: the `dv=0` pair that marks end of frame reaches the FSM at edge k+3.
- Throughput: one byte per cycle, back-to-back `out_valid` for the whole frame. Frames separated by a single `dv=0` cycle are handled; minimum interframe gap is 1 cycle.
- `R` asserted mid-frame: all state clears immediately, no `out_last` is produced for the cut frame, counters read 0. After release with `dv` still high, the remainder is handled as a fresh start, normally IDLE -> DROP.

## Test plan
- Frame: 7×0x55, 0xD5, bytes 0x01..0x40, then `dv=0` -> 64 beats 0x01..0x40, `out_last` on 0x40 only, `out_error=0`, `frame_count=1`, first beat 3 cycles after the first payload byte's rising edge.
- Same frame with RX_ER asserted (falling-edge `ctl`=0) on payload byte 10 -> all 64 bytes delivered, `out_error=1` on the last beat, `frame_count=1`.
- Frame starting 0x55, 0x55, 0xA5, … -> no `out_valid`, `drop_count=1` once `dv` falls; an immediate good frame after 1 idle cycle is delivered intact.
- 0x55, 0xD5, then `dv=0` -> no beats, `drop_count=1`; false carrier (`dv=0`, `er=1`) for 20 cycles -> no effect.
- Two back-to-back 1-byte frames (0xAA, then 0xBB) with 1-cycle gap -> two beats, each with `out_last=1`, `frame_count=2`.
- `R` pulsed during payload byte 30 -> outputs and counters 0 at once, rest of frame dropped (`drop_count=1`), next frame delivered normally. Run 65536 good frames -> `frame_count` wraps to 0.
